rv32i_writeback: RTL

RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/rv32i_wb_tagfifo.sv | 68 ++++++
 rtl/rv32i_writeback.sv | 98 +++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared widths and the retirement / bank-write records used by the writeback stage.
// bank_map turns a retiring result into the drive of the two 16-entry register banks.
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_IDX_W  = 5;
   localparam int BANK_IDX_W = 4;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } retire_t;

   typedef struct packed {
      logic [BANK_IDX_W-1:0] idx;
      logic                  lo_we;
      logic                  hi_we;
      logic [XLEN-1:0]       din;
   } bank_wr_t;

   // The top index bit selects the bank; x0 retires without touching either bank.
   function automatic bank_wr_t bank_map(input retire_t r);
      bank_wr_t w;
      w = '0;
      if (r.valid) begin
         w.idx = r.rd[BANK_IDX_W-1:0];
         w.din = r.data;
         if (r.rd != X0_IDX) begin
            w.lo_we = ~r.rd[REG_IDX_W-1];
            w.hi_we =  r.rd[REG_IDX_W-1];
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/rv32i_wb_tagfifo.sv
// In-order FIFO of destination registers for outstanding loads.
// A push while full is dropped; push and pop may coincide whenever the FIFO is non-empty.
module rv32i_wb_tagfifo
   import rv32i_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [REG_IDX_W-1:0] push_rd_i,
   input  logic                 pop_i,
   output logic [REG_IDX_W-1:0] head_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [REG_IDX_W-1:0] mem_q [LD_DEPTH];
   logic [REG_IDX_W-1:0] mem_d [LD_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q,  count_d;
   logic                 push_ok;
   logic                 pop_ok;

   assign full_o  = (count_q == CNT_W'(LD_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i  & ~empty_o;

   // Pointers wrap by natural overflow since LD_DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_rd_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry contents are only meaningful while counted, so they carry no reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rv32i_writeback.sv
// Writeback stage: retires ALU results and in-order load responses into the split
// register banks, tracks registers with loads in flight and raises decode stalls.
module rv32i_writeback
   import rv32i_pkg::*;
#(
   parameter int LD_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  alu_valid_i,
   input  logic [REG_IDX_W-1:0]  alu_rd_i,
   input  logic [XLEN-1:0]       alu_data_i,
   input  logic                  ld_issue_i,
   input  logic [REG_IDX_W-1:0]  ld_rd_i,
   input  logic                  ld_valid_i,
   input  logic [XLEN-1:0]       ld_data_i,
   output logic                  ld_ready_o,
   input  logic [REG_IDX_W-1:0]  dec_rs1_i,
   input  logic [REG_IDX_W-1:0]  dec_rs2_i,
   input  logic [REG_IDX_W-1:0]  dec_rd_i,
   input  logic                  dec_is_load_i,
   output logic                  stall_o,
   output logic                  ld_full_o,
   output logic [BANK_IDX_W-1:0] wr_rd_16_o,
   output logic [XLEN-1:0]       wr_din_o,
   output logic                  wr_lo_we_o,
   output logic                  wr_hi_we_o
);

   logic [NUM_REGS-1:0]  busy_q, busy_d;
   bank_wr_t             wr_q, wr_d;
   retire_t              retire;
   logic [REG_IDX_W-1:0] fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 issue_acc;
   logic                 resp_acc;

   rv32i_wb_tagfifo #(
      .LD_DEPTH (LD_DEPTH)
   ) u_tagfifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (ld_issue_i),
      .push_rd_i (ld_rd_i),
      .pop_i     (resp_acc),
      .head_o    (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Load response handshake: a response transfers in a cycle where ld_valid_i and
   // ld_ready_o are both high. The ALU owns the write port whenever it has a result,
   // and ready stays low while no load tag is outstanding.
   assign ld_ready_o = ~alu_valid_i & ~fifo_empty;
   assign resp_acc   = ld_valid_i & ld_ready_o;
   assign issue_acc  = ld_issue_i & ~fifo_full;
   assign ld_full_o  = fifo_full;

   // Set after clear so a register reissued as its load completes stays busy.
   always_comb begin
      busy_d = busy_q;
      if (resp_acc) begin
         busy_d[fifo_head] = 1'b0;
      end
      if (issue_acc) begin
         busy_d[ld_rd_i] = 1'b1;
      end
      busy_d[X0_IDX] = 1'b0;
   end

   always_comb begin
      retire       = '0;
      retire.valid = alu_valid_i | resp_acc;
      retire.rd    = alu_valid_i ? alu_rd_i   : fifo_head;
      retire.data  = alu_valid_i ? alu_data_i : ld_data_i;
      wr_d         = bank_map(retire);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
         wr_q   <= '0;
      end else begin
         busy_q <= busy_d;
         wr_q   <= wr_d;
      end
   end

   assign stall_o = busy_q[dec_rs1_i] | busy_q[dec_rs2_i] | busy_q[dec_rd_i]
                  | (dec_is_load_i & fifo_full);

   assign wr_rd_16_o = wr_q.idx;
   assign wr_din_o   = wr_q.din;
   assign wr_lo_we_o = wr_q.lo_we;
   assign wr_hi_we_o = wr_q.hi_we;

endmodule
